// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port: one request at a time, fixed access
// latency, byte/half/word accesses with extension on loads and misalignment/range error reporting.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] AddrLimit = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            req_err;
  logic            access_en;
  logic [AW-1:0]   mem_idx;
  logic [1:0]      lane;
  logic [31:0]     mem_rword;
  logic [31:0]     rword_shifted;
  logic [31:0]     load_data;
  logic [31:0]     wdata_rep;
  logic [3:0]      byte_en;

  assign req_err = (req_size_i == 2'b11)
                 | ((req_size_i == 2'b01) & req_addr_i[0])
                 | ((req_size_i == 2'b10) & (|req_addr_i[1:0]))
                 | (req_addr_i >= AddrLimit);

  assign mem_idx       = addr_q[AW+1:2];
  assign lane          = addr_q[1:0];
  assign mem_rword     = mem_q[mem_idx];
  assign rword_shifted = mem_rword >> {lane, 3'b000};
  assign access_en     = (state_q == StWait) && (cnt_q == '0) && !err_q;

  always_comb begin
    load_data = mem_rword;
    wdata_rep = wdata_q;
    byte_en   = 4'b1111;
    case (size_q)
      2'b00: begin
        load_data = unsigned_q ? {24'b0, rword_shifted[7:0]}
                               : {{24{rword_shifted[7]}}, rword_shifted[7:0]};
        wdata_rep = {4{wdata_q[7:0]}};
        byte_en   = 4'b0001 << lane;
      end
      2'b01: begin
        load_data = unsigned_q ? {16'b0, rword_shifted[15:0]}
                               : {{16{rword_shifted[15]}}, rword_shifted[15:0]};
        wdata_rep = {2{wdata_q[15:0]}};
        byte_en   = 4'b0011 << lane;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          write_d    = req_write_i;
          addr_d     = req_addr_i[AW+1:0];
          wdata_d    = req_wdata_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          rdata_d    = '0;
          err_d      = req_err;
          state_d    = StWait;
          // Errors spend a single cycle in WAIT so rsp_valid follows one edge after acceptance.
          cnt_d      = req_err ? '0 : CntW'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rdata_d = (err_q || write_q) ? '0 : load_data;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Array is not reset; a reset forces StIdle, so a pending store never lands.
  always_ff @(posedge clk_i) begin
    if (access_en && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem_q[mem_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
